// File: rtl/ts_sync_framer.sv
// Byte-stream packet synchroniser: finds the repeating sync byte, locks onto the
// packet grid and forwards aligned bytes with a start-of-packet marker.
module ts_sync_framer #(
    parameter int unsigned PKT_LEN   = 204,
    parameter logic [7:0]  SYNC_BYTE = 8'h47,
    parameter logic [7:0]  SYNC_INV  = 8'hB8,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned LOSS_CNT  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       locked,
    output logic       sync_err
);

    localparam int unsigned POS_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(PKT_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_TGT  = BAD_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;

    logic       out_valid_d;
    logic [7:0] out_data_d;
    logic       out_sof_d;
    logic       locked_d;
    logic       sync_err_d;

    logic              is_sync_c;
    logic              at_sync_pos_c;
    logic [POS_W-1:0]  pos_inc_c;
    logic [GOOD_W-1:0] good_inc_c;
    logic [BAD_W-1:0]  bad_inc_c;

    assign is_sync_c     = (in_data == SYNC_BYTE) || (in_data == SYNC_INV);
    assign at_sync_pos_c = (pos_q == '0);
    assign pos_inc_c     = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    assign good_inc_c    = good_q + GOOD_W'(1);
    assign bad_inc_c     = bad_q + BAD_W'(1);

    // Next-state and next-output logic; nothing moves without in_valid.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        good_d      = good_q;
        bad_d       = bad_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        sync_err_d  = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (is_sync_c) begin
                        pos_d  = POS_W'(1);
                        good_d = GOOD_W'(1);
                        bad_d  = '0;
                        if (LOCK_CNT == 1) begin
                            state_d     = LOCKED;
                            out_valid_d = 1'b1;
                            out_sof_d   = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    pos_d = pos_inc_c;
                    if (at_sync_pos_c) begin
                        if (is_sync_c) begin
                            good_d = good_inc_c;
                            if (good_inc_c == GOOD_TGT) begin
                                state_d     = LOCKED;
                                bad_d       = '0;
                                out_valid_d = 1'b1;
                                out_sof_d   = 1'b1;
                            end
                        end else begin
                            // Failed candidate: drop it, this byte is not re-examined.
                            state_d = SEARCH;
                            good_d  = '0;
                            pos_d   = '0;
                        end
                    end
                end

                LOCKED: begin
                    pos_d       = pos_inc_c;
                    out_valid_d = 1'b1;
                    out_sof_d   = at_sync_pos_c;
                    if (at_sync_pos_c) begin
                        if (is_sync_c) begin
                            bad_d = '0;
                        end else begin
                            sync_err_d = 1'b1;
                            if (bad_inc_c == BAD_TGT) begin
                                // Lock lost: the offending byte is reported but not forwarded.
                                state_d     = SEARCH;
                                out_valid_d = 1'b0;
                                out_sof_d   = 1'b0;
                                good_d      = '0;
                                bad_d       = '0;
                                pos_d       = '0;
                            end else begin
                                bad_d = bad_inc_c;
                            end
                        end
                    end
                end

                default: begin
                    state_d = SEARCH;
                    pos_d   = '0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end

        out_data_d = out_valid_d ? in_data : out_data;
        locked_d   = (state_d == LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEARCH;
            pos_q     <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_sof   <= out_sof_d;
            locked    <= locked_d;
            sync_err  <= sync_err_d;
        end
    end

endmodule
